dpi_regex_ctx_mgr: RTL

Parametrised per-stream context manager for one DFA regex matcher in the kraaken DPI core.
- Saves and restores DFA state per stream ID across packets.
- Registers all DFA inputs and outputs for timing.
- Tracks a per-packet sticky match flag and a saturating match count.
- Next generation of the fixed-width netbios wrapper. Adds:
  - generic widths;
  - internal stream-valid tracking, replacing the external new_stream_id;
  - stream flush;
  - drain/commit FSM with in_rdy backpressure;
  - read-after-write bypass.
- Sits between the packet parser/stream classifier and an external DFA core.

---
 rtl/dpi_ctx_pkg.sv | 11 +
 rtl/dpi_ctx_ram.sv | 33 +++
 rtl/dpi_regex_ctx_mgr.sv | 93 +++++++++
 3 files changed

// File: rtl/dpi_ctx_pkg.sv
// dpi_ctx_pkg: shared FSM states, parameter defaults and the drain-counter width helper.
package dpi_ctx_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, COMMIT} ctx_state_e;
  localparam int STATE_W_DEF = 11;
  localparam int STREAM_W_DEF = 6;
  localparam int COUNT_W_DEF = 16;
  localparam int DFA_LAT_DEF = 1;
  function automatic int drain_w(input int lat);
    return $clog2(lat + 2);
  endfunction
endpackage

// File: rtl/dpi_ctx_ram.sv
// dpi_ctx_ram: per-stream DFA state store with valid bits, flush and commit-to-restore bypass.
module dpi_ctx_ram
  import dpi_ctx_pkg::*;
#(
  parameter int STATE_W = STATE_W_DEF,
  parameter int STREAM_W = STREAM_W_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [STREAM_W-1:0] rd_id,
  output logic [STATE_W-1:0]  rd_data,
  input  logic                wr_en,
  input  logic [STREAM_W-1:0] wr_id,
  input  logic [STATE_W-1:0]  wr_data,
  input  logic                flush_vld,
  input  logic [STREAM_W-1:0] flush_id
);
  logic [STATE_W-1:0] mem [2**STREAM_W];
  logic [2**STREAM_W-1:0] valid;
  always_ff @(posedge clk)
    if (wr_en) mem[wr_id] <= wr_data;
  // flush is applied after the commit write so it wins on a collision
  always_ff @(posedge clk)
    if (!rst_n) valid <= '0;
    else begin
      if (wr_en) valid[wr_id] <= 1'b1;
      if (flush_vld) valid[flush_id] <= 1'b0;
    end
  always_comb
    rd_data = (flush_vld && flush_id == rd_id) ? '0 :
              (wr_en && wr_id == rd_id) ? wr_data :
              valid[rd_id] ? mem[rd_id] : '0;
endmodule

// File: rtl/dpi_regex_ctx_mgr.sv
// dpi_regex_ctx_mgr: per-stream DFA context save/restore with packet FSM, match flag and count.
module dpi_regex_ctx_mgr
  import dpi_ctx_pkg::*;
#(
  parameter int STATE_W = STATE_W_DEF,
  parameter int STREAM_W = STREAM_W_DEF,
  parameter int COUNT_W = COUNT_W_DEF,
  parameter int DFA_LAT = DFA_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pkt_sop,
  input  logic [STREAM_W-1:0] stream_id,
  input  logic                enable,
  input  logic [7:0]          char_in,
  input  logic                char_in_vld,
  input  logic                pkt_eop,
  output logic                in_rdy,
  input  logic                flush_vld,
  input  logic [STREAM_W-1:0] flush_id,
  input  logic                clr_count,
  output logic [7:0]          dfa_char,
  output logic                dfa_char_vld,
  output logic [STATE_W-1:0]  dfa_state_in,
  output logic                dfa_state_in_vld,
  input  logic [STATE_W-1:0]  dfa_state_out,
  input  logic                dfa_accept,
  output logic                fired,
  output logic                pkt_done,
  output logic [COUNT_W-1:0]  count
);
  localparam int DW = drain_w(DFA_LAT);
  ctx_state_e st;
  logic [DW-1:0] drain;
  logic [STREAM_W-1:0] sid;
  logic en, accept_r, sop_ok, act, wr_en, drain_done;
  logic [STATE_W-1:0] state_r, rd_data;
  always_comb begin
    in_rdy = st == IDLE || st == COMMIT;
    sop_ok = pkt_sop && in_rdy;
    act = st == ACTIVE;
    wr_en = st == COMMIT && en;
    drain_done = st == DRAIN && drain == DW'(1);
  end
  dpi_ctx_ram #(.STATE_W(STATE_W), .STREAM_W(STREAM_W)) u_ram (
    .clk(clk), .rst_n(rst_n), .rd_id(stream_id), .rd_data(rd_data),
    .wr_en(wr_en), .wr_id(sid), .wr_data(state_r),
    .flush_vld(flush_vld), .flush_id(flush_id)
  );
  always_ff @(posedge clk)
    if (!rst_n) begin
      st <= IDLE;
      drain <= '0;
      sid <= '0;
      en <= 1'b0;
      state_r <= '0;
      accept_r <= 1'b0;
      dfa_char <= '0;
      dfa_char_vld <= 1'b0;
      dfa_state_in <= '0;
      dfa_state_in_vld <= 1'b0;
      fired <= 1'b0;
      pkt_done <= 1'b0;
      count <= '0;
    end else begin
      state_r <= dfa_state_out;
      accept_r <= dfa_accept;
      dfa_char_vld <= act && char_in_vld;
      dfa_char <= (act && char_in_vld) ? char_in : '0;
      dfa_state_in_vld <= sop_ok;
      if (sop_ok) begin
        dfa_state_in <= rd_data;
        sid <= stream_id;
        en <= enable;
      end
      pkt_done <= drain_done;
      // the commit-cycle accept is still in accept_r, so it counts alongside fired
      fired <= (sop_ok || (st == COMMIT && !en)) ? 1'b0 : fired || (accept_r && st != IDLE);
      count <= clr_count ? '0 : (wr_en && (fired || accept_r) && !(&count)) ? count + 1'b1 : count;
      case (st)
        IDLE: if (sop_ok) st <= ACTIVE;
        ACTIVE: if (pkt_eop) begin
          st <= DRAIN;
          drain <= DW'(DFA_LAT + 1);
        end
        DRAIN: begin
          drain <= drain - 1'b1;
          if (drain_done) st <= COMMIT;
        end
        default: st <= sop_ok ? ACTIVE : IDLE;
      endcase
    end
endmodule
